// File: rtl/app_cmd_gen.sv
// Splits a block-transfer request into READ/WRITE DMA EXT commands of at most
// MAX_SECTORS sectors and streams each as a 3-word AXI-stream packet.
module app_cmd_gen #(
    parameter int unsigned MAX_SECTORS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sata_link_up,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [47:0] req_lba,
    input  logic [31:0] req_count,
    output logic        command_m_axi_tvalid,
    output logic        command_m_axi_tlast,
    input  logic        command_m_axi_tready,
    output logic [31:0] command_m_axi_tdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] MAX_CNT  = 32'(MAX_SECTORS);
    localparam logic [7:0]  OP_WRITE = 8'h35;
    localparam logic [7:0]  OP_READ  = 8'h25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [47:0] lba_q, lba_d;
    logic [31:0] remaining_q, remaining_d;
    logic        req_ready_q, req_ready_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [31:0] tdata_q, tdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] chunk;
    logic        accept;
    logic        handshake;

    function automatic logic [15:0] chunk_of(input logic [31:0] rem);
        return (rem > MAX_CNT) ? MAX_CNT[15:0] : rem[15:0];
    endfunction

    // Word presented while in state st; computed from next-state values so
    // the registered output is already correct on the cycle the state is entered.
    function automatic logic [31:0] word_of(input state_t      st,
                                            input logic        wr,
                                            input logic [47:0] lba,
                                            input logic [31:0] rem);
        logic [31:0] w;
        w = 32'h0;
        case (st)
            W0:      w = {(wr ? OP_WRITE : OP_READ), 8'h00, chunk_of(rem)};
            W1:      w = lba[31:0];
            W2:      w = {16'h0000, lba[47:32]};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign chunk     = chunk_of(remaining_q);
    assign accept    = req_valid & req_ready_q;
    assign handshake = tvalid_q & command_m_axi_tready;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        lba_d       = lba_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_count == 32'd0) begin
                        err_d = 1'b1;
                    end else begin
                        write_d     = req_write;
                        lba_d       = req_lba;
                        remaining_d = req_count;
                        state_d     = W0;
                    end
                end
            end
            W0: begin
                if (!sata_link_up) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (handshake) begin
                    state_d = W1;
                end
            end
            W1: begin
                if (!sata_link_up) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (handshake) begin
                    state_d = W2;
                end
            end
            W2: begin
                if (!sata_link_up) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (handshake) begin
                    lba_d       = lba_q + {32'h0, chunk};
                    remaining_d = remaining_q - {16'h0, chunk};
                    if (remaining_d == 32'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = W0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        tvalid_d = busy_d;
        tlast_d  = (state_d == W2);
        tdata_d  = word_of(state_d, write_d, lba_d, remaining_d);
        // Ready re-opens one cycle after busy falls (or after a reject).
        req_ready_d = sata_link_up & ~busy_q & (state_d == IDLE) & ~accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            lba_q       <= 48'h0;
            remaining_q <= 32'h0;
            req_ready_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            lba_q       <= lba_d;
            remaining_q <= remaining_d;
            req_ready_q <= req_ready_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready            = req_ready_q;
    assign command_m_axi_tvalid = tvalid_q;
    assign command_m_axi_tlast  = tlast_q;
    assign command_m_axi_tdata  = tdata_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err                  = err_q;

endmodule

// File: tb/tb_app_cmd_gen.sv
// Randomized bench for app_cmd_gen against a chunk-list reference model.
module tb_app_cmd_gen;

    localparam int MAXS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        link;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [47:0] req_lba;
    logic [31:0] req_count;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [31:0] tdata;
    logic        busy;
    logic        done;
    logic        err;

    app_cmd_gen #(.MAX_SECTORS(MAXS)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sata_link_up         (link),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_lba              (req_lba),
        .req_count            (req_count),
        .command_m_axi_tvalid (tvalid),
        .command_m_axi_tlast  (tlast),
        .command_m_axi_tready (tready),
        .command_m_axi_tdata  (tdata),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic [32:0] ref_q[$];
    int          done_cnt, err_cnt, done_cyc;
    logic        busy_seen;
    logic        stall_pend = 1'b0;
    logic [32:0] held;
    logic        bp_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid && tready) obs_q.push_back({tlast, tdata});
        if (stall_pend && tvalid) chk("stall_stable", 64'({tlast, tdata}), 64'(held));
        stall_pend = tvalid && !tready && !rst;
        held       = {tlast, tdata};
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    // Reference: list of chunks, each producing three words.
    task automatic build_exp(input logic wr, input logic [47:0] lba, input logic [31:0] cnt);
        longint      rem;
        longint      c;
        logic [47:0] a;
        logic [15:0] c16;
        exp_q.delete();
        rem = longint'(cnt);
        a   = lba;
        while (rem > 0) begin
            c   = (rem < MAXS) ? rem : MAXS;
            c16 = 16'(c);
            exp_q.push_back({1'b0, (wr ? 8'h35 : 8'h25), 8'h00, c16});
            exp_q.push_back({1'b0, a[31:0]});
            exp_q.push_back({1'b1, 16'h0000, a[47:32]});
            a   = a + 48'(c);
            rem = rem - c;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) tready = 1'($urandom);
    endtask

    task automatic clear_mon();
        obs_q.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        done_cyc  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic start_req(input logic wr, input logic [47:0] lba, input logic [31:0] cnt,
                             output int acc_cyc);
        int t;
        t = 0;
        while (!req_ready && t < 200) begin
            tick();
            t++;
        end
        if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_lba   = lba;
        req_count = cnt;
        tick();
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic run_req(input logic wr, input logic [47:0] lba, input logic [31:0] cnt);
        int acc, t, n, nchunks;
        build_exp(wr, lba, cnt);
        clear_mon();
        start_req(wr, lba, cnt, acc);
        if (cnt == 0) begin
            chk("rej_err_n1", 64'(err), 64'(1));
            chk("rej_tvalid", 64'(tvalid), 64'(0));
        end else begin
            chk("w0_valid_n1", 64'(tvalid), 64'(1));
            chk("busy_n1", 64'(busy), 64'(1));
        end
        t = 0;
        while (done_cnt + err_cnt == 0 && t < 5000) begin
            tick();
            t++;
        end
        if (done_cnt + err_cnt == 0) chk("end_timeout", 64'(0), 64'(1));
        repeat (3) tick();
        chk("n_words", 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("word", 64'(obs_q[i]), 64'(exp_q[i]));
        if (cnt == 0) begin
            chk("rej_err_cnt", 64'(err_cnt), 64'(1));
            chk("rej_busy", 64'(busy_seen), 64'(0));
            chk("rej_done", 64'(done_cnt), 64'(0));
        end else begin
            chk("done_cnt", 64'(done_cnt), 64'(1));
            chk("err_cnt", 64'(err_cnt), 64'(0));
            if (!bp_mode) begin
                nchunks = int'((64'(cnt) + MAXS - 1) / MAXS);
                chk("latency", 64'(done_cyc - acc), 64'(3 * nchunks));
            end
        end
    endtask

    initial begin
        int          acc;
        logic        wr;
        logic [47:0] lba;
        logic [31:0] cnt;

        rst = 1'b1; link = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_lba = 48'h0; req_count = 32'h0; tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({req_ready, tvalid, tlast, tdata, busy, done, err}), 64'(0));
        rst = 1'b0;
        tick();
        tick();

        // Directed read, single chunk
        run_req(1'b0, 48'h0000_1234_5678, 32'd16);
        chk("rd_w0", 64'(obs_q[0]), 64'({1'b0, 32'h25000010}));
        chk("rd_w1", 64'(obs_q[1]), 64'({1'b0, 32'h12345678}));
        chk("rd_w2", 64'(obs_q[2]), 64'({1'b1, 32'h00000000}));

        // Directed write across the 48-bit LBA wrap
        run_req(1'b1, 48'hFFFF_FFFF_FF80, 32'd600);
        chk("wr_p0_w0", 64'(obs_q[0]), 64'({1'b0, 32'h35000100}));
        chk("wr_p0_w1", 64'(obs_q[1]), 64'({1'b0, 32'hFFFFFF80}));
        chk("wr_p0_w2", 64'(obs_q[2]), 64'({1'b1, 32'h0000FFFF}));
        chk("wr_p1_w1", 64'(obs_q[4]), 64'({1'b0, 32'h00000080}));
        chk("wr_p2_w0", 64'(obs_q[6]), 64'({1'b0, 32'h35000058}));
        chk("wr_p2_w1", 64'(obs_q[7]), 64'({1'b0, 32'h00000180}));

        // Same 300-sector write without and with backpressure
        run_req(1'b1, 48'h0000_0001_0000, 32'd300);
        ref_q = obs_q;
        bp_mode = 1'b1;
        run_req(1'b1, 48'h0000_0001_0000, 32'd300);
        bp_mode = 1'b0;
        tready  = 1'b1;
        chk("bp_len", 64'(obs_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++)
            chk("bp_word", 64'(obs_q[i]), 64'(ref_q[i]));

        // Zero-count reject
        run_req(1'b0, 48'h0000_0000_1000, 32'd0);

        // Link drop while W1 is stalled
        clear_mon();
        start_req(1'b1, 48'h0000_0000_0100, 32'd300, acc);
        tick();
        chk("ld_w1_valid", 64'(tvalid), 64'(1));
        tready = 1'b0;
        link   = 1'b0;
        tick();
        chk("ld_tvalid", 64'(tvalid), 64'(0));
        chk("ld_err", 64'(err), 64'(1));
        chk("ld_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        chk("ld_ready_low", 64'(req_ready), 64'(0));
        chk("ld_err_cnt", 64'(err_cnt), 64'(1));
        chk("ld_done_cnt", 64'(done_cnt), 64'(0));
        chk("ld_words", 64'(obs_q.size()), 64'(1));
        link   = 1'b1;
        tready = 1'b1;
        tick();
        chk("ld_ready_back", 64'(req_ready), 64'(1));

        // Asynchronous reset in W2
        clear_mon();
        start_req(1'b1, 48'h0, 32'd600, acc);
        tick();
        tick();
        chk("rst_in_w2", 64'(tlast), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_outs", 64'({req_ready, tvalid, tlast, tdata, busy, done, err}), 64'(0));
        tick();
        rst = 1'b0;
        run_req(1'b0, 48'h0000_ABCD_0000, 32'd40);

        // Randomized requests
        for (int k = 0; k < 10; k++) begin
            wr  = 1'($urandom);
            lba = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 2) == 0) lba = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 600));
            cnt = 32'($urandom_range(1, 900));
            bp_mode = 1'($urandom);
            run_req(wr, lba, cnt);
            bp_mode = 1'b0;
            tready  = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/app_cmd_gen.md
# app_cmd_gen

Command generator sitting directly upstream of the SATA application layer's command & address AXI-stream input. It accepts a single block-transfer request (direction, 48-bit LBA, 32-bit sector count) from user logic. It splits the request into one or more commands of at most MAX_SECTORS sectors each, and emits each command as a 3-word AXI-stream packet. It only accepts work while the SATA link is up, and aborts cleanly if the link drops.

## Interface
Parameters:
- MAX_SECTORS, 256, largest sector count per emitted command; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sata_link_up  input  1  link status; high means the link is usable.
- req_valid  input  1  request strobe.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_write  input  1  1 = write (WRITE DMA EXT), 0 = read (READ DMA EXT).
- req_lba  input  48  starting LBA.
- req_count  input  32  total sectors requested.
- command_m_axi_tvalid  output  1  command word valid.
- command_m_axi_tlast  output  1  marks the final word of a command.
- command_m_axi_tready  input  1  downstream ready.
- command_m_axi_tdata  output  32  command word.
- busy  output  1  high from request acceptance until done or err.
- done  output  1  one-cycle pulse when a request completes.
- err  output  1  one-cycle pulse on a rejected or aborted request.

## Operation
- Command packet, 3 words (tlast only on W2):
  - W0: [31:24] opcode, 0x35 for write or 0x25 for read; [23:16] = 0; [15:0] = chunk sector count.
  - W1: LBA[31:0].
  - W2: [31:16] = 0; [15:0] = LBA[47:32].
- FSM states are IDLE, W0, W1, W2.
- IDLE:
  - req_ready = sata_link_up & ~busy.
  - On acceptance with req_count == 0: no packet is emitted, err pulses, and the FSM stays in IDLE.
  - On acceptance otherwise: latch direction, lba and remaining = req_count, then go to W0.
- Chunking:
  - chunk = min(remaining, MAX_SECTORS). It is computed combinationally from registered remaining and held stable for the whole packet.
- W0→W1→W2: each transition happens on a tvalid & tready handshake.
- On the W2 handshake:
  - lba ← lba + chunk, wrapping modulo 2^48 with no error flag.
  - remaining ← remaining − chunk.
  - If the new remaining is 0: go to IDLE and pulse done. Otherwise go to W0 for the next chunk.
- Link drop (sata_link_up low) in W0/W1/W2:
  - Deassert tvalid on the next cycle, go to IDLE and pulse err.
  - This deliberately breaks the AXI-stream hold rule; the downstream layer discards partial commands on link loss.
- Link drop in IDLE: req_ready goes low; no other effect.
- rst (asynchronous) returns the FSM to IDLE from any state.

## Timing
- Reset values: req_ready 0, command_m_axi_tvalid 0, command_m_axi_tlast 0, command_m_axi_tdata 0, busy 0, done 0, err 0. All outputs are registered.
- Request accepted in cycle N: W0 is valid in cycle N+1 and busy is high from N+1.
- Each word holds tdata, tvalid and tlast stable until its handshake completes. With tready held high the throughput is 1 word per cycle.
- No bubble between chunks: W0 of the next chunk is valid the cycle after the previous W2 handshake.
- done or err pulses in the cycle after the terminating event. busy falls in that same cycle, and req_ready can rise one cycle later.
- Zero-count reject: err pulses at N+1 and tvalid never asserts.
- Minimum request latency with tready always high: 3·ceil(count/MAX_SECTORS) cycles from N+1 to the final handshake.

## Test plan
- Read, lba=0x0000_1234_5678, count=16, tready=1 → three words in consecutive cycles: 0x25000010, 0x12345678, 0x00000000 (tlast on the third); done pulses once.
- Write, lba=0xFFFF_FFFF_FF80, count=600, MAX_SECTORS=256 → three packets:
  - counts 256 / 256 / 88;
  - LBAs 0xFFFFFFFFFF80, 0x000000000080 (48-bit wrap), 0x000000000180;
  - done pulses only after the last packet.
- Random tready backpressure on a count=300 write → the word sequence is identical to the no-backpressure run and tdata is stable on every stalled cycle.
- req_count=0 → req accepted, err pulse one cycle later, no tvalid, busy stays 0.
- sata_link_up dropped while W1 is stalled (tready=0) → tvalid low the next cycle, err pulses, FSM returns to IDLE; req_ready stays 0 until the link returns.
- rst asserted mid-W2 → all outputs take their reset values immediately; a new request then completes normally.
